// File: rtl/pac_port_arb_pkg.sv
// Shared definitions for the packet-granular egress arbiter: word tags, widths and FSM encodings.
package pac_port_arb_pkg;

    localparam int PKT_DW  = 134;
    localparam int FIFO_DW = PKT_DW + 1;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    function automatic logic [1:0] pkt_tag(input logic [PKT_DW-1:0] word);
        return word[PKT_DW-1 -: 2];
    endfunction

endpackage

// File: rtl/pac_arb_fifo.sv
// First-word-fall-through synchronous FIFO holding one input stream plus its pkt-good bit.
module pac_arb_fifo
    import pac_port_arb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_din,
    input  logic          i_rd,
    output logic [DW-1:0] o_dout,
    output logic          o_empty,
    output logic [AW:0]   o_used
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Pointers carry one extra bit so full and empty are told apart without a separate flag.
    assign o_used  = r_wptr - r_rptr;
    assign o_empty = (o_used == '0);
    assign w_full  = (o_used == (AW+1)'(DEPTH));
    assign w_push  = i_wr && !w_full;
    assign w_pop   = i_rd && !o_empty;
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pac_port_arb.sv
// Round-robin arbiter granting whole packets from two buffered pkt streams onto one egress port.
module pac_port_arb
    import pac_port_arb_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int MAX_PKT = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PKT_DW-1:0] i_in0_data,
    input  logic              i_in0_data_wr,
    input  logic              i_in0_valid,
    input  logic              i_in0_valid_wr,
    input  logic [PKT_DW-1:0] i_in1_data,
    input  logic              i_in1_data_wr,
    input  logic              i_in1_valid,
    input  logic              i_in1_valid_wr,
    input  logic              i_out_alf,
    output logic [PKT_DW-1:0] o_out_data,
    output logic              o_out_data_wr,
    output logic              o_out_valid,
    output logic              o_out_valid_wr,
    output logic [31:0]       o_drop_cnt0,
    output logic [31:0]       o_drop_cnt1,
    output logic [63:0]       o_pktout_cnt
);

    logic [PKT_DW-1:0]  w_in_data [2];
    logic [1:0]         w_in_wr;
    logic [1:0]         w_in_vld;
    logic [1:0]         w_in_vwr;
    logic [1:0]         w_is_head;
    logic [1:0]         w_is_tail;
    logic [1:0]         w_room;
    logic [1:0]         w_fifo_wr;
    logic [1:0]         w_tail_wr;
    logic [1:0]         w_pop;
    logic [1:0]         w_tail_pop;
    logic [1:0]         w_empty;
    logic [FIFO_DW-1:0] w_fifo_din [2];
    logic [FIFO_DW-1:0] w_dout [2];
    logic [AW:0]        w_used [2];
    logic [FIFO_DW-1:0] w_sel_dout;
    logic               w_sel_empty;
    logic               w_elig0;
    logic               w_elig1;
    logic               w_pick;

    logic [1:0]         r_acc;
    logic [31:0]        r_drop [2];
    logic [AW:0]        r_pktq [2];
    logic [0:0]         r_state;
    logic               r_last_grant;

    assign w_in_data[0] = i_in0_data;
    assign w_in_data[1] = i_in1_data;
    assign w_in_wr      = {i_in1_data_wr, i_in0_data_wr};
    assign w_in_vld     = {i_in1_valid, i_in0_valid};
    assign w_in_vwr     = {i_in1_valid_wr, i_in0_valid_wr};

    // A head is admitted only if a maximum-length pkt is guaranteed to fit behind it.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_is_head[i]  = w_in_wr[i] && (pkt_tag(w_in_data[i]) == TAG_HEAD);
            w_is_tail[i]  = w_in_wr[i] && (pkt_tag(w_in_data[i]) == TAG_TAIL);
            w_room[i]     = (((AW+1)'(DEPTH) - w_used[i]) >= (AW+1)'(MAX_PKT));
            w_fifo_wr[i]  = w_is_head[i] ? w_room[i] : (w_in_wr[i] && r_acc[i]);
            w_fifo_din[i] = {w_is_tail[i] && w_in_vld[i] && w_in_vwr[i], w_in_data[i]};
            w_tail_wr[i]  = w_is_tail[i] && r_acc[i] && (w_used[i] != (AW+1)'(DEPTH));
            w_pop[i]      = (r_state == ST_SEND) && (r_last_grant == i[0]) && !w_empty[i];
            w_tail_pop[i] = w_pop[i] && (pkt_tag(w_dout[i][PKT_DW-1:0]) == TAG_TAIL);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : gen_fifo
        pac_arb_fifo #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .DW    (FIFO_DW)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_wr    (w_fifo_wr[g]),
            .i_din   (w_fifo_din[g]),
            .i_rd    (w_pop[g]),
            .o_dout  (w_dout[g]),
            .o_empty (w_empty[g]),
            .o_used  (w_used[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_drop[0] <= '0;
            r_drop[1] <= '0;
            r_pktq[0] <= '0;
            r_pktq[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_is_head[i]) begin
                    r_acc[i] <= w_room[i];
                    if (!w_room[i] && (r_drop[i] != '1)) begin
                        r_drop[i] <= r_drop[i] + 32'd1;
                    end
                end else if (w_is_tail[i]) begin
                    r_acc[i] <= 1'b0;
                end
                if (w_tail_wr[i] && !w_tail_pop[i]) begin
                    r_pktq[i] <= r_pktq[i] + (AW+1)'(1);
                end else if (!w_tail_wr[i] && w_tail_pop[i]) begin
                    r_pktq[i] <= r_pktq[i] - (AW+1)'(1);
                end
            end
        end
    end

    assign o_drop_cnt0 = r_drop[0];
    assign o_drop_cnt1 = r_drop[1];

    // last_grant doubles as the active grant while a pkt is being sent.
    assign w_elig0     = (r_pktq[0] != '0);
    assign w_elig1     = (r_pktq[1] != '0);
    assign w_pick      = (w_elig0 && w_elig1) ? !r_last_grant : w_elig1;
    assign w_sel_dout  = r_last_grant ? w_dout[1] : w_dout[0];
    assign w_sel_empty = r_last_grant ? w_empty[1] : w_empty[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= 1'b1;
            o_out_data     <= '0;
            o_out_data_wr  <= 1'b0;
            o_out_valid    <= 1'b0;
            o_out_valid_wr <= 1'b0;
            o_pktout_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_out_data_wr  <= 1'b0;
                    o_out_valid_wr <= 1'b0;
                    if (!i_out_alf && (w_elig0 || w_elig1)) begin
                        r_last_grant <= w_pick;
                        r_state      <= ST_SEND;
                    end
                end
                default: begin
                    if (!w_sel_empty) begin
                        o_out_data    <= w_sel_dout[PKT_DW-1:0];
                        o_out_data_wr <= 1'b1;
                        if (pkt_tag(w_sel_dout[PKT_DW-1:0]) == TAG_TAIL) begin
                            o_out_valid    <= w_sel_dout[PKT_DW];
                            o_out_valid_wr <= 1'b1;
                            o_pktout_cnt   <= o_pktout_cnt + 64'd1;
                            r_state        <= ST_IDLE;
                        end else begin
                            o_out_valid_wr <= 1'b0;
                        end
                    end else begin
                        o_out_data_wr  <= 1'b0;
                        o_out_valid_wr <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pac_port_arb.sv
// Directed scenario bench for pac_port_arb: each task drives one feature and checks its own results.
module tb_pac_port_arb;
    import pac_port_arb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [PKT_DW-1:0] in0_data;
    logic              in0_data_wr;
    logic              in0_valid;
    logic              in0_valid_wr;
    logic [PKT_DW-1:0] in1_data;
    logic              in1_data_wr;
    logic              in1_valid;
    logic              in1_valid_wr;
    logic              out_alf;
    logic [PKT_DW-1:0] o_out_data;
    logic              o_out_data_wr;
    logic              o_out_valid;
    logic              o_out_valid_wr;
    logic [31:0]       o_drop_cnt0;
    logic [31:0]       o_drop_cnt1;
    logic [63:0]       o_pktout_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [PKT_DW-1:0] q_data [$];
    logic              q_vwr  [$];
    logic              q_val  [$];
    int                q_cyc  [$];

    pac_port_arb #(
        .DEPTH   (256),
        .AW      (8),
        .MAX_PKT (128)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in0_data     (in0_data),
        .i_in0_data_wr  (in0_data_wr),
        .i_in0_valid    (in0_valid),
        .i_in0_valid_wr (in0_valid_wr),
        .i_in1_data     (in1_data),
        .i_in1_data_wr  (in1_data_wr),
        .i_in1_valid    (in1_valid),
        .i_in1_valid_wr (in1_valid_wr),
        .i_out_alf      (out_alf),
        .o_out_data     (o_out_data),
        .o_out_data_wr  (o_out_data_wr),
        .o_out_valid    (o_out_valid),
        .o_out_valid_wr (o_out_valid_wr),
        .o_drop_cnt0    (o_drop_cnt0),
        .o_drop_cnt1    (o_drop_cnt1),
        .o_pktout_cnt   (o_pktout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted word with its strobe flags and the cycle it was visible.
    always @(negedge clk) begin
        if (rst_n && o_out_data_wr) begin
            q_data.push_back(o_out_data);
            q_vwr.push_back(o_out_valid_wr);
            q_val.push_back(o_out_valid);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [PKT_DW-1:0] mkword(input logic [1:0] tag, input int base, input int k);
        logic [15:0] b;
        logic [15:0] kk;
        b  = base[15:0];
        kk = k[15:0];
        return {tag, 100'd0, b, kk};
    endfunction

    function automatic logic [1:0] tag_for(input int k, input int n);
        if (k == 0)     return TAG_HEAD;
        if (k == n - 1) return TAG_TAIL;
        return TAG_MID;
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_vwr.delete();
        q_val.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        in0_data = '0; in0_data_wr = 1'b0; in0_valid = 1'b0; in0_valid_wr = 1'b0;
        in1_data = '0; in1_data_wr = 1'b0; in1_valid = 1'b0; in1_valid_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        out_alf = 1'b0;
        clear_inputs();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_q();
    endtask

    task automatic send_pkt(input int port, input int n, input int base, input logic vld, output int tcyc);
        tcyc = 0;
        for (int k = 0; k < n; k++) begin
            if (port == 0) begin
                in0_data = mkword(tag_for(k, n), base, k); in0_data_wr = 1'b1;
                in0_valid_wr = (k == n - 1); in0_valid = vld;
            end else begin
                in1_data = mkword(tag_for(k, n), base, k); in1_data_wr = 1'b1;
                in1_valid_wr = (k == n - 1); in1_valid = vld;
            end
            if (k == n - 1) tcyc = cyc;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic send_pair(input int n, input int base0, input int base1, output int tcyc);
        tcyc = 0;
        for (int k = 0; k < n; k++) begin
            in0_data = mkword(tag_for(k, n), base0, k); in0_data_wr = 1'b1;
            in0_valid_wr = (k == n - 1); in0_valid = 1'b1;
            in1_data = mkword(tag_for(k, n), base1, k); in1_data_wr = 1'b1;
            in1_valid_wr = (k == n - 1); in1_valid = 1'b1;
            if (k == n - 1) tcyc = cyc;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic wait_words(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (q_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        out_alf = 1'b0;
        clear_inputs();
        idle(3);
        total++;
        if (o_out_data_wr !== 1'b0 || o_out_valid_wr !== 1'b0 || o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b%b%b exp=000", o_out_data_wr, o_out_valid_wr, o_out_valid);
        end
        total++;
        if (o_out_data !== '0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", o_out_data);
        end
        total++;
        if (o_drop_cnt0 !== 32'd0 || o_drop_cnt1 !== 32'd0 || o_pktout_cnt !== 64'd0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", o_drop_cnt0, o_drop_cnt1, o_pktout_cnt);
        end
        rst_n = 1'b1;
        idle(2);
        clear_q();
    endtask

    task automatic test_single();
        int tc;
        bit ok;
        int nvwr;
        do_reset();
        send_pkt(0, 4, 16'h11, 1'b1, tc);
        wait_words(4, 50, ok);
        idle(3);
        total++;
        if (!ok || q_data.size() != 4) begin
            bad++; $display("FAIL single_count got=%0d exp=4", q_data.size());
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_data[k] !== mkword(tag_for(k, 4), 16'h11, k)) begin
                bad++; $display("FAIL single_word%0d got=%h exp=%h", k, q_data[k], mkword(tag_for(k, 4), 16'h11, k));
            end
        end
        total++;
        if (q_cyc[0] != tc + 3 || q_cyc[3] != tc + 6) begin
            bad++; $display("FAIL single_latency got=%0d,%0d exp=%0d,%0d", q_cyc[0], q_cyc[3], tc + 3, tc + 6);
        end
        nvwr = 0;
        foreach (q_vwr[j]) if (q_vwr[j]) nvwr++;
        total++;
        if (nvwr != 1 || q_vwr[3] !== 1'b1 || q_val[3] !== 1'b1) begin
            bad++; $display("FAIL single_valid got=n%0d vwr%b val%b exp=n1 vwr1 val1", nvwr, q_vwr[3], q_val[3]);
        end
        total++;
        if (o_pktout_cnt !== 64'd1) begin
            bad++; $display("FAIL single_pktout got=%0d exp=1", o_pktout_cnt);
        end
    endtask

    task automatic test_tie();
        int tc;
        bit ok;
        do_reset();
        send_pair(3, 16'h21, 16'h22, tc);
        wait_words(6, 60, ok);
        idle(3);
        total++;
        if (!ok || q_data.size() != 6) begin
            bad++; $display("FAIL tie_count got=%0d exp=6", q_data.size());
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (q_data[k] !== mkword(tag_for(k % 3, 3), (k < 3) ? 16'h21 : 16'h22, k % 3)) begin
                bad++; $display("FAIL tie_word%0d got=%h exp=%h", k, q_data[k],
                                mkword(tag_for(k % 3, 3), (k < 3) ? 16'h21 : 16'h22, k % 3));
            end
        end
        total++;
        if (q_cyc[0] != tc + 3 || q_cyc[3] != q_cyc[2] + 2) begin
            bad++; $display("FAIL tie_timing got=%0d,%0d exp=%0d,%0d", q_cyc[0], q_cyc[3], tc + 3, q_cyc[2] + 2);
        end
        clear_q();
        send_pair(3, 16'h23, 16'h24, tc);
        wait_words(6, 60, ok);
        idle(3);
        total++;
        if (!ok || q_data[0] !== mkword(TAG_HEAD, 16'h23, 0) || q_data[3] !== mkword(TAG_HEAD, 16'h24, 0)) begin
            bad++; $display("FAIL tie_alternate got=%h,%h exp=%h,%h", q_data[0], q_data[3],
                            mkword(TAG_HEAD, 16'h23, 0), mkword(TAG_HEAD, 16'h24, 0));
        end
        total++;
        if (o_pktout_cnt !== 64'd4) begin
            bad++; $display("FAIL tie_pktout got=%0d exp=4", o_pktout_cnt);
        end
    endtask

    task automatic test_drop();
        int tc;
        bit ok;
        do_reset();
        out_alf = 1'b1;
        send_pkt(0, 64, 16'h31, 1'b1, tc);
        send_pkt(0, 64, 16'h32, 1'b1, tc);
        send_pkt(0, 2, 16'h33, 1'b1, tc);
        idle(2);
        total++;
        if (o_drop_cnt0 !== 32'd0) begin
            bad++; $display("FAIL drop_boundary got=%0d exp=0", o_drop_cnt0);
        end
        out_alf = 1'b0;
        wait_words(130, 400, ok);
        idle(6);
        total++;
        if (!ok || q_data.size() != 130 || q_data[129] !== mkword(TAG_TAIL, 16'h33, 1)) begin
            bad++; $display("FAIL drop_boundary_out got=%0d words last=%h exp=130 %h", q_data.size(),
                            q_data[129], mkword(TAG_TAIL, 16'h33, 1));
        end
        clear_q();
        out_alf = 1'b1;
        send_pkt(0, 65, 16'h34, 1'b1, tc);
        send_pkt(0, 64, 16'h35, 1'b1, tc);
        send_pkt(0, 4, 16'h36, 1'b1, tc);
        idle(2);
        total++;
        if (o_drop_cnt0 !== 32'd1 || o_drop_cnt1 !== 32'd0) begin
            bad++; $display("FAIL drop_count got=%0d/%0d exp=1/0", o_drop_cnt0, o_drop_cnt1);
        end
        out_alf = 1'b0;
        wait_words(129, 400, ok);
        idle(10);
        total++;
        if (!ok || q_data.size() != 129 || q_data[128] !== mkword(TAG_TAIL, 16'h35, 63)) begin
            bad++; $display("FAIL drop_drain got=%0d words last=%h exp=129 %h", q_data.size(),
                            q_data[128], mkword(TAG_TAIL, 16'h35, 63));
        end
        clear_q();
        send_pkt(0, 3, 16'h37, 1'b1, tc);
        wait_words(3, 50, ok);
        idle(3);
        total++;
        if (!ok || q_data.size() != 3 || q_data[0] !== mkword(TAG_HEAD, 16'h37, 0) ||
            q_data[2] !== mkword(TAG_TAIL, 16'h37, 2)) begin
            bad++; $display("FAIL drop_recover got=%0d words head=%h exp=3 %h", q_data.size(),
                            q_data[0], mkword(TAG_HEAD, 16'h37, 0));
        end
    endtask

    task automatic test_alf();
        int tc;
        bit ok;
        bit seen;
        do_reset();
        out_alf = 1'b1;
        send_pkt(0, 5, 16'h41, 1'b1, tc);
        send_pkt(0, 3, 16'h42, 1'b1, tc);
        idle(10);
        total++;
        if (q_data.size() != 0 || o_out_data_wr !== 1'b0) begin
            bad++; $display("FAIL alf_block got=%0d words exp=0", q_data.size());
        end
        out_alf = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_out_data_wr) begin
                seen = 1'b1;
                break;
            end
        end
        out_alf = 1'b1;
        @(negedge clk);
        out_alf = 1'b0;
        total++;
        if (!seen) begin
            bad++; $display("FAIL alf_release got=no_output exp=output");
        end
        wait_words(8, 60, ok);
        idle(4);
        total++;
        if (!ok || q_data.size() != 8) begin
            bad++; $display("FAIL alf_count got=%0d exp=8", q_data.size());
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (q_data[k] !== mkword((k < 5) ? tag_for(k, 5) : tag_for(k - 5, 3), (k < 5) ? 16'h41 : 16'h42,
                                     (k < 5) ? k : k - 5)) begin
                bad++; $display("FAIL alf_word%0d got=%h", k, q_data[k]);
            end
        end
        total++;
        if (q_cyc[4] != q_cyc[0] + 4 || q_cyc[5] != q_cyc[4] + 2) begin
            bad++; $display("FAIL alf_timing got=%0d,%0d exp=%0d,%0d", q_cyc[4], q_cyc[5], q_cyc[0] + 4, q_cyc[4] + 2);
        end
    endtask

    task automatic test_valid0();
        int tc;
        bit ok;
        clear_q();
        send_pkt(1, 3, 16'h51, 1'b0, tc);
        wait_words(3, 50, ok);
        idle(3);
        total++;
        if (!ok || q_data.size() != 3 || q_data[1] !== mkword(TAG_MID, 16'h51, 1) ||
            q_data[2] !== mkword(TAG_TAIL, 16'h51, 2)) begin
            bad++; $display("FAIL valid0_words got=%0d words mid=%h exp=3 %h", q_data.size(), q_data[1],
                            mkword(TAG_MID, 16'h51, 1));
        end
        total++;
        if (q_vwr[0] !== 1'b0 || q_vwr[2] !== 1'b1 || q_val[2] !== 1'b0) begin
            bad++; $display("FAIL valid0_flag got=vwr%b%b val%b exp=vwr01 val0", q_vwr[0], q_vwr[2], q_val[2]);
        end
    endtask

    task automatic test_async_reset();
        int tc;
        bit ok;
        bit seen;
        clear_q();
        send_pkt(0, 6, 16'h61, 1'b1, tc);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_out_data_wr) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (!seen || o_out_data_wr !== 1'b0 || o_out_valid_wr !== 1'b0 || o_out_data !== '0 ||
            o_pktout_cnt !== 64'd0) begin
            bad++; $display("FAIL arst_outputs got=seen%b wr%b vwr%b cnt%0d exp=seen1 wr0 vwr0 cnt0",
                            seen, o_out_data_wr, o_out_valid_wr, o_pktout_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in0_data = mkword(TAG_MID, 16'h61, 3); in0_data_wr = 1'b1;
        @(negedge clk);
        in0_data = mkword(TAG_TAIL, 16'h61, 4); in0_valid_wr = 1'b1; in0_valid = 1'b1;
        @(negedge clk);
        clear_inputs();
        clear_q();
        idle(10);
        total++;
        if (q_data.size() != 0 || o_pktout_cnt !== 64'd0) begin
            bad++; $display("FAIL arst_stray got=%0d words cnt%0d exp=0 cnt0", q_data.size(), o_pktout_cnt);
        end
        send_pkt(0, 3, 16'h62, 1'b1, tc);
        wait_words(3, 50, ok);
        idle(3);
        total++;
        if (!ok || q_data.size() != 3 || q_data[0] !== mkword(TAG_HEAD, 16'h62, 0) || o_pktout_cnt !== 64'd1) begin
            bad++; $display("FAIL arst_clean got=%0d words head=%h cnt%0d exp=3 %h cnt1", q_data.size(), q_data[0],
                            o_pktout_cnt, mkword(TAG_HEAD, 16'h62, 0));
        end
    endtask

    initial begin
        $display("[TB] starting pac_port_arb bench");
        test_reset();
        test_single();
        test_tie();
        test_drop();
        test_alf();
        test_valid0();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
